// File: rtl/prog_ctr_gen.sv
// prog_ctr_gen: fetch-stage program counter with multi-cycle stall, abs/relative
// branches and freeze. Define PROG_CTR_RAS_EN to add a circular return-address stack.
module prog_ctr_gen #(
  parameter int PC_W         = 10,
  parameter int OFF_W        = 6,
  parameter int STALL_CYCLES = 4,
  parameter int RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Hold,
  input  logic             MultiCyc,
  input  logic             BranchEn,
  input  logic             Cond,
  input  logic             Relative,
  input  logic [OFF_W-1:0] Offset,
  input  logic [PC_W-1:0]  Target,
  input  logic             Call,
  input  logic             Ret,
  output logic [PC_W-1:0]  PC,
  output logic             Busy,
  output logic             Taken,
  output logic             RasErr
);

  localparam int CNT_W = 4;
  localparam bit STALLS = (STALL_CYCLES > 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [PC_W-1:0]    pc_q, pc_inc, npc, off_ext;
  logic               taken_q, ntaken;
  logic               stall_start, advance;
  logic               push, pop, ras_err_set;
  logic signed [OFF_W-1:0] off_s;

  assign off_s   = Offset;
  assign off_ext = PC_W'(off_s);
  assign pc_inc  = pc_q + PC_W'(1);
  assign stall_start = STALLS && MultiCyc;

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!Start) state_d = RUN;
      RUN:     if (stall_start) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (Start)     state_d = IDLE;
    else if (Hold) state_d = state_q;
  end

  // FSM outputs: advance marks the cycle an instruction retires and PC loads
  always_comb begin
    Busy    = (state_q == WAIT);
    advance = 1'b0;
    if (!Start && !Hold)
      advance = (state_q == RUN && !stall_start) || (state_q == WAIT && cnt_q == '0);
  end

`ifdef PROG_CTR_RAS_EN
  localparam int SP_W = $clog2(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][PC_W-1:0] ras_mem;
  logic [SP_W-1:0]                sp_q;
  logic [SP_W:0]                  ras_cnt_q;
  logic                           raserr_q;
  logic                           ras_empty, ras_full;

  assign ras_empty = (ras_cnt_q == '0);
  assign ras_full  = (ras_cnt_q == (SP_W+1)'(RAS_DEPTH));
  assign RasErr    = raserr_q;
`else
  localparam int unused_depth = RAS_DEPTH;
  logic unused_ras;
  assign unused_ras = ^{Call, Ret};
  assign RasErr     = 1'b0;
`endif

  // next_pc select: Ret > Call > taken branch > sequential
  always_comb begin
    npc         = pc_inc;
    ntaken      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    ras_err_set = 1'b0;
`ifdef PROG_CTR_RAS_EN
    if (Ret) begin
      if (ras_empty) ras_err_set = 1'b1;
      else begin
        pop    = 1'b1;
        npc    = ras_mem[sp_q - SP_W'(1)];
        ntaken = 1'b1;
      end
    end else if (Call) begin
      push        = 1'b1;
      npc         = Target;
      ntaken      = 1'b1;
      ras_err_set = ras_full;
    end else
`endif
    if (BranchEn && Cond) begin
      npc    = Relative ? (pc_q + off_ext) : Target;
      ntaken = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || Start) begin
      pc_q    <= '0;
      cnt_q   <= '0;
      taken_q <= 1'b0;
    end else if (Hold) begin
      taken_q <= 1'b0;
    end else begin
      taken_q <= advance & ntaken;
      if (advance) pc_q <= npc;
      if (state_q == RUN && stall_start)   cnt_q <= CNT_W'(STALL_CYCLES - 2);
      else if (state_q == WAIT && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

`ifdef PROG_CTR_RAS_EN
  // Full push overwrites the oldest slot; occupancy saturates at RAS_DEPTH
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sp_q      <= '0;
      ras_cnt_q <= '0;
      raserr_q  <= 1'b0;
    end else if (!Start && advance) begin
      if (ras_err_set) raserr_q <= 1'b1;
      if (push) begin
        ras_mem[sp_q] <= pc_inc;
        sp_q          <= sp_q + SP_W'(1);
        if (!ras_full) ras_cnt_q <= ras_cnt_q + (SP_W+1)'(1);
      end else if (pop) begin
        sp_q      <= sp_q - SP_W'(1);
        ras_cnt_q <= ras_cnt_q - (SP_W+1)'(1);
      end
    end
  end
`endif

  assign PC    = pc_q;
  assign Taken = taken_q;

endmodule

// File: doc/prog_ctr_gen.md
Name: prog_ctr_gen

Overview:
Parametrised program counter for the fetch stage. It generalises the 8-bit counter with a fixed 4-cycle stall to a configurable PC width, a configurable multi-cycle stall length, absolute and PC-relative conditional branches, and a single-cycle freeze. An optional return-address stack adds call/return. It drives the instruction-ROM address and takes its control inputs from the decoder and ALU flags.

Parameters:
PC_W, 10, PC width in bits; all PC arithmetic is modulo 2^PC_W
OFF_W, 6, width of the signed relative-branch offset
STALL_CYCLES, 4, total cycles occupied by a multi-cycle instruction (1..16)
RAS_DEPTH, 4, return-stack entries (power of 2, 2..16); used only with RAS_EN

Ports:
Clk  in  1  clock
Reset  in  1  reset; synchronous, active-high
Start  in  1  level; while high, PC is held at 0 in IDLE
Hold  in  1  freeze all state for this cycle (PC, FSM, counter, stack)
MultiCyc  in  1  current instruction occupies STALL_CYCLES cycles
BranchEn  in  1  current instruction is a conditional branch
Cond  in  1  branch condition flag (ALU Zero)
Relative  in  1  1: target = PC + sext(Offset); 0: target = Target
Offset  in  OFF_W  signed relative offset
Target  in  PC_W  absolute branch/call target
Call  in  1  push PC+1, jump to Target (RAS_EN only)
Ret  in  1  pop stack into PC (RAS_EN only)
PC  out  PC_W  current instruction address
Busy  out  1  high while in WAIT
Taken  out  1  registered; high the cycle after PC was loaded from a non-sequential source
RasErr  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset has top priority: PC=0, state=IDLE, cnt=0, Busy=0, Taken=0, RasErr=0, stack pointer=0, stack empty. This applies in every state, including mid-WAIT.
- Start=1 (not in Reset), any state: PC<=0, state<=IDLE, cnt<=0, Taken<=0. Stack and RasErr are retained.
- Hold=1 (not in Reset, Start=0): all registers keep their values; Taken<=0.
- IDLE: PC stays 0. When Start=0, go to RUN. No PC update happens in the transition cycle, so the first instruction fetched is address 0.
- RUN, MultiCyc=0: PC<=next_pc every cycle.
- RUN, MultiCyc=1, STALL_CYCLES>1: PC is held; state<=WAIT; cnt<=STALL_CYCLES-2.
- RUN, MultiCyc=1, STALL_CYCLES=1: behaves as MultiCyc=0.
- WAIT: Busy=1 and PC is held. If cnt!=0, cnt<=cnt-1. If cnt==0, PC<=next_pc using inputs sampled this cycle, then state<=RUN.
- A MultiCyc instruction therefore occupies exactly STALL_CYCLES cycles. MultiCyc is ignored while in WAIT.
- next_pc priority:
  - Ret (RAS_EN): top of stack
  - Call (RAS_EN): Target
  - BranchEn & Cond: Relative ? PC+sext(Offset) : Target
  - otherwise: PC+1
- PC+1 and relative targets wrap modulo 2^PC_W; for example, PC=2^PC_W-1 increments to 0.
- Taken<=1 when the PC load comes from a branch, call or return; otherwise Taken<=0.

Optional Feature:
Macro: PROG_CTR_RAS_EN
- Defined: a RAS_DEPTH x PC_W circular stack is instantiated.
- Call pushes PC+1 and jumps to Target.
- Ret pops into PC.
- Pushing when full overwrites the oldest entry and sets RasErr.
- Ret when empty selects PC+1 and sets RasErr.
- Call and Ret asserted together: Ret wins and no push occurs.
- Not defined: Call and Ret are ignored, no stack storage exists, RasErr is tied to 0.

Test Plan:
- Reset, then Start=1 for 3 cycles, then Start=0 -> PC=0 held, one cycle in IDLE->RUN at PC=0, then PC 1,2,3 on successive cycles.
- PC_W=4, free-run from PC=14 -> PC goes 15, 0, 1; Taken stays 0.
- PC=5, BranchEn=1, Relative=1, Offset=-3, Cond=1 -> PC=2, Taken=1 the next cycle. Same stimulus with Cond=0 -> PC=6.
- PC=8, MultiCyc=1, STALL_CYCLES=4, BranchEn=1, Cond=1, Relative=0, Target=40 asserted only in the last WAIT cycle -> PC stays 8 for 4 cycles, Busy=1 for 3 cycles, then PC=40.
- Hold=1 in the second WAIT cycle, then Reset mid-WAIT -> the stall stretches by one cycle; after Reset, PC=0, Busy=0, state=IDLE.
- PROG_CTR_RAS_EN, RAS_DEPTH=2: Call from PC=3 (Target=20), Call from PC=20 (Target=30), then Ret, Ret -> PC sequence 20, 30, 21, 4. A third Ret -> PC=5 and RasErr=1.
